// File: rtl/soc_it_data_pkg.sv
// Shared widths and beat payload for the SoC-IT slave data bridge.
package soc_it_data_pkg;

   localparam int unsigned SOC_IT_TAG_W  = 4;
   localparam int unsigned SOC_IT_DATA_W = 128;

   typedef struct packed {
      logic [SOC_IT_TAG_W-1:0]  tag;
      logic [SOC_IT_DATA_W-1:0] data;
   } soc_it_beat_t;

endpackage

// File: rtl/soc_it_sync_fifo.sv
// Synchronous FIFO with a registered head beat, registered full/empty flags and occupancy.
module soc_it_sync_fifo
   import soc_it_data_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter type         beat_t = soc_it_beat_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  beat_t                      din,
   output logic                       push_ready,
   input  logic                       pop,
   output beat_t                      head,
   output logic                       head_valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   beat_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  rd_ptr_n;
   logic [CW-1:0]  count_n;
   beat_t          head_n;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && push_ready;
   assign do_pop  = pop && head_valid;

   // Next occupancy and next head; a push into an (effectively) empty FIFO bypasses storage.
   always_comb begin
      count_n  = count;
      rd_ptr_n = rd_ptr;
      head_n   = '0;
      if (do_push && !do_pop) begin
         count_n = count + CW'(1);
      end else if (!do_push && do_pop) begin
         count_n = count - CW'(1);
      end
      if (do_pop) begin
         rd_ptr_n = rd_ptr + AW'(1);
      end
      if (count_n != '0) begin
         if (do_push && (count == (do_pop ? CW'(1) : CW'(0)))) begin
            head_n = din;
         end else begin
            head_n = mem[rd_ptr_n];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head       <= '0;
         head_valid <= 1'b0;
         push_ready <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr     <= rd_ptr_n;
         count      <= count_n;
         head       <= head_n;
         head_valid <= (count_n != '0);
         push_ready <= (count_n != CW'(DEPTH));
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/soc_it_slave_data_bridge.sv
// SoC-IT slave data port termination: buffered write path to the backend and
// tag-gated, in-order read-return path to the master, with a sticky tag-stall monitor.
module soc_it_slave_data_bridge
   import soc_it_data_pkg::*;
#(
   parameter int unsigned WR_DEPTH       = 16,
   parameter int unsigned RD_DEPTH       = 16,
   parameter bit          STRICT_TAG     = 1'b1,
   parameter int unsigned MISMATCH_LIMIT = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          master_datain_src_rdy,
   output logic                          master_datain_dst_rdy,
   input  logic [3:0]                    master_datain_tag,
   input  logic [127:0]                  master_datain,
   output logic                          master_dataout_src_rdy,
   input  logic                          master_dataout_dst_rdy,
   input  logic [3:0]                    master_dataout_tag,
   output logic [127:0]                  master_dataout,
   output logic                          wr_valid,
   input  logic                          wr_ready,
   output logic [3:0]                    wr_tag,
   output logic [127:0]                  wr_data,
   input  logic                          rd_valid,
   output logic                          rd_ready,
   input  logic [3:0]                    rd_tag,
   input  logic [127:0]                  rd_data,
   output logic [$clog2(WR_DEPTH+1)-1:0] wr_count,
   output logic [$clog2(RD_DEPTH+1)-1:0] rd_count,
   output logic                          err_tag_mismatch
);

   localparam int unsigned SW = $clog2(MISMATCH_LIMIT+1);

   soc_it_beat_t  wr_in;
   soc_it_beat_t  wr_head;
   soc_it_beat_t  rd_in;
   soc_it_beat_t  rd_head;
   logic          rd_head_valid;
   logic          tag_match;
   logic          rd_pop;
   logic          stall;
   logic [SW-1:0] stall_cnt;

   assign wr_in = '{tag: master_datain_tag, data: master_datain};
   assign rd_in = '{tag: rd_tag, data: rd_data};

   soc_it_sync_fifo #(
      .DEPTH  (WR_DEPTH),
      .beat_t (soc_it_beat_t)
   ) u_wr_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (master_datain_src_rdy),
      .din        (wr_in),
      .push_ready (master_datain_dst_rdy),
      .pop        (wr_ready),
      .head       (wr_head),
      .head_valid (wr_valid),
      .count      (wr_count)
   );

   assign wr_tag  = wr_head.tag;
   assign wr_data = wr_head.data;

   soc_it_sync_fifo #(
      .DEPTH  (RD_DEPTH),
      .beat_t (soc_it_beat_t)
   ) u_rd_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (rd_valid),
      .din        (rd_in),
      .push_ready (rd_ready),
      .pop        (rd_pop),
      .head       (rd_head),
      .head_valid (rd_head_valid),
      .count      (rd_count)
   );

   // Head beat is released only when the master asks for its tag; it blocks everything behind it.
   assign tag_match              = (rd_head.tag == master_dataout_tag);
   assign master_dataout_src_rdy = rd_head_valid && (!STRICT_TAG || tag_match);
   assign rd_pop                 = master_dataout_src_rdy && master_dataout_dst_rdy;
   assign master_dataout         = rd_head.data;

   assign stall = STRICT_TAG && rd_head_valid && master_dataout_dst_rdy && !tag_match;

   // Consecutive tag-stall cycles; error latches once the run reaches the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt        <= '0;
         err_tag_mismatch <= 1'b0;
      end else if (stall) begin
         if (stall_cnt != SW'(MISMATCH_LIMIT)) begin
            stall_cnt <= stall_cnt + SW'(1);
         end
         if (stall_cnt == SW'(MISMATCH_LIMIT - 1)) begin
            err_tag_mismatch <= 1'b1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_soc_it_slave_data_bridge.sv
// Directed self-checking bench for soc_it_slave_data_bridge.
module tb_soc_it_slave_data_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         master_datain_src_rdy;
   logic         master_datain_dst_rdy;
   logic [3:0]   master_datain_tag;
   logic [127:0] master_datain;
   logic         master_dataout_src_rdy;
   logic         master_dataout_dst_rdy;
   logic [3:0]   master_dataout_tag;
   logic [127:0] master_dataout;
   logic         wr_valid;
   logic         wr_ready;
   logic [3:0]   wr_tag;
   logic [127:0] wr_data;
   logic         rd_valid;
   logic         rd_ready;
   logic [3:0]   rd_tag;
   logic [127:0] rd_data;
   logic [4:0]   wr_count;
   logic [4:0]   rd_count;
   logic         err_tag_mismatch;

   int n_cmp = 0;
   int n_err = 0;

   logic [131:0] wr_got[$];
   logic [131:0] md_got[$];

   soc_it_slave_data_bridge #(
      .WR_DEPTH       (16),
      .RD_DEPTH       (16),
      .STRICT_TAG     (1'b1),
      .MISMATCH_LIMIT (64)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .master_datain_src_rdy  (master_datain_src_rdy),
      .master_datain_dst_rdy  (master_datain_dst_rdy),
      .master_datain_tag      (master_datain_tag),
      .master_datain          (master_datain),
      .master_dataout_src_rdy (master_dataout_src_rdy),
      .master_dataout_dst_rdy (master_dataout_dst_rdy),
      .master_dataout_tag     (master_dataout_tag),
      .master_dataout         (master_dataout),
      .wr_valid               (wr_valid),
      .wr_ready               (wr_ready),
      .wr_tag                 (wr_tag),
      .wr_data                (wr_data),
      .rd_valid               (rd_valid),
      .rd_ready               (rd_ready),
      .rd_tag                 (rd_tag),
      .rd_data                (rd_data),
      .wr_count               (wr_count),
      .rd_count               (rd_count),
      .err_tag_mismatch       (err_tag_mismatch)
   );

   always #5 clk = ~clk;

   // Record completed transfers mid-cycle, when inputs and outputs are settled.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_valid && wr_ready) wr_got.push_back({wr_tag, wr_data});
         if (master_dataout_src_rdy && master_dataout_dst_rdy)
            md_got.push_back({master_dataout_tag, master_dataout});
      end
   end

   task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] wdata(input int j);
      return {32'(j), 32'hCAFE_F00D, 32'(j * 3), 32'h1234_5678};
   endfunction

   function automatic logic [127:0] rdata(input int j);
      return {32'h8765_4321, 32'(j * 7), 32'hBEEF_0000, 32'(j)};
   endfunction

   int max_cnt;

   initial begin
      rst = 1'b1;
      master_datain_src_rdy = 1'b0; master_datain_tag = '0; master_datain = '0;
      master_dataout_dst_rdy = 1'b0; master_dataout_tag = '0;
      wr_ready = 1'b0; rd_valid = 1'b0; rd_tag = '0; rd_data = '0;
      step(2);

      // Reset state
      check("rst_datain_dst_rdy", 132'(master_datain_dst_rdy), 132'(0));
      check("rst_rd_ready", 132'(rd_ready), 132'(0));
      check("rst_wr_valid", 132'(wr_valid), 132'(0));
      check("rst_dataout_src_rdy", 132'(master_dataout_src_rdy), 132'(0));
      check("rst_counts", 132'({wr_count, rd_count}), 132'(0));
      check("rst_err", 132'(err_tag_mismatch), 132'(0));
      rst = 1'b0;
      step();
      check("post_rst_readies", 132'({master_datain_dst_rdy, rd_ready}), 132'(2'b11));

      // Write streaming, 20 beats
      wr_ready = 1'b1;
      max_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         master_datain_src_rdy = 1'b1;
         master_datain_tag = 4'(i);
         master_datain = 128'(i);
         step();
         if (i == 0) check("wr_first_latency", 132'(wr_valid), 132'(1));
         if (int'(wr_count) > max_cnt) max_cnt = int'(wr_count);
      end
      master_datain_src_rdy = 1'b0;
      step(3);
      check("wr_stream_max_count", 132'(max_cnt), 132'(1));
      check("wr_stream_n", 132'(wr_got.size()), 132'(20));
      for (int j = 0; j < 20; j++) check("wr_stream_beat", wr_got[j], {4'(j), 128'(j)});
      wr_got.delete();

      // Write full and no pop-through
      wr_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         master_datain_src_rdy = 1'b1;
         master_datain_tag = 4'(i);
         master_datain = 128'(100 + i);
         step();
      end
      check("wr_full_count", 132'(wr_count), 132'(16));
      check("wr_full_dst_rdy", 132'(master_datain_dst_rdy), 132'(0));
      wr_ready = 1'b1;
      step();
      check("wr_pop_only_count", 132'(wr_count), 132'(15));
      check("wr_pop_only_dst_rdy", 132'(master_datain_dst_rdy), 132'(1));
      check("wr_pop_only_beat", wr_got[0], {4'd0, 128'd100});
      wr_ready = 1'b0;
      step();
      check("wr_refill_count", 132'(wr_count), 132'(16));
      master_datain_src_rdy = 1'b0;
      wr_ready = 1'b1;
      step(18);
      check("wr_full_drain_n", 132'(wr_got.size()), 132'(17));
      check("wr_full_beat15", wr_got[15], {4'd15, 128'd115});
      check("wr_full_beat16", wr_got[16], {4'd0, 128'd116});
      check("wr_drained_count", 132'(wr_count), 132'(0));
      wr_got.delete();
      wr_ready = 1'b0;

      // Read tag match and head-of-line blocking
      master_dataout_dst_rdy = 1'b1;
      master_dataout_tag = 4'd7;
      rd_valid = 1'b1; rd_tag = 4'd5; rd_data = 128'h55;
      step();
      rd_tag = 4'd7; rd_data = 128'h77;
      step();
      rd_valid = 1'b0;
      step(2);
      check("rd_blocked_src_rdy", 132'(master_dataout_src_rdy), 132'(0));
      check("rd_blocked_count", 132'(rd_count), 132'(2));
      check("rd_blocked_data", 132'(master_dataout), 132'(128'h55));
      check("rd_blocked_n", 132'(md_got.size()), 132'(0));
      master_dataout_tag = 4'd5;
      #1;
      check("rd_match_src_rdy", 132'(master_dataout_src_rdy), 132'(1));
      step();
      check("rd_after_pop5_count", 132'(rd_count), 132'(1));
      check("rd_after_pop5_src_rdy", 132'(master_dataout_src_rdy), 132'(0));
      master_dataout_tag = 4'd7;
      step();
      check("rd_after_pop7_count", 132'(rd_count), 132'(0));
      check("rd_match_n", 132'(md_got.size()), 132'(2));
      check("rd_match_beat0", md_got[0], {4'd5, 128'h55});
      check("rd_match_beat1", md_got[1], {4'd7, 128'h77});
      check("rd_match_no_err", 132'(err_tag_mismatch), 132'(0));

      // Tag-stall error after 64 blocked cycles
      master_dataout_dst_rdy = 1'b0;
      rd_valid = 1'b1; rd_tag = 4'd3; rd_data = 128'h33;
      step();
      rd_valid = 1'b0;
      master_dataout_tag = 4'd9;
      master_dataout_dst_rdy = 1'b1;
      step(63);
      check("stall_63_err", 132'(err_tag_mismatch), 132'(0));
      step();
      check("stall_64_err", 132'(err_tag_mismatch), 132'(1));
      master_dataout_tag = 4'd3;
      step();
      check("stall_release_n", 132'(md_got.size()), 132'(3));
      check("stall_release_beat", md_got[2], {4'd3, 128'h33});
      step(3);
      check("stall_err_sticky", 132'(err_tag_mismatch), 132'(1));

      // Reset mid-operation with both FIFOs holding 8 beats
      md_got.delete();
      wr_got.delete();
      wr_ready = 1'b0;
      master_dataout_dst_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         master_datain_src_rdy = 1'b1; master_datain_tag = 4'(i); master_datain = 128'(200 + i);
         rd_valid = 1'b1; rd_tag = 4'(i); rd_data = 128'(300 + i);
         step();
      end
      master_datain_src_rdy = 1'b0;
      rd_valid = 1'b0;
      check("mid_fill_counts", 132'({wr_count, rd_count}), 132'({5'd8, 5'd8}));
      rst = 1'b1;
      step();
      check("mid_rst_counts", 132'({wr_count, rd_count}), 132'(0));
      check("mid_rst_flags", 132'({master_datain_dst_rdy, rd_ready, wr_valid, master_dataout_src_rdy, err_tag_mismatch}), 132'(0));
      check("mid_rst_data", 132'({wr_tag, wr_data, master_dataout}), 132'(0));
      rst = 1'b0;
      step();
      check("mid_post_readies", 132'({master_datain_dst_rdy, rd_ready, wr_valid}), 132'(3'b110));
      wr_ready = 1'b1;
      master_dataout_dst_rdy = 1'b1;
      master_dataout_tag = 4'd0;
      step(5);
      check("mid_no_stale_wr", 132'(wr_got.size()), 132'(0));
      check("mid_no_stale_rd", 132'(md_got.size()), 132'(0));

      // Concurrent full-rate traffic, 100 beats each way
      for (int i = 0; i <= 100; i++) begin
         if (i < 100) begin
            master_datain_src_rdy = 1'b1; master_datain_tag = 4'(i * 3); master_datain = wdata(i);
            rd_valid = 1'b1; rd_tag = 4'(i * 5); rd_data = rdata(i);
         end else begin
            master_datain_src_rdy = 1'b0;
            rd_valid = 1'b0;
         end
         if (i >= 1) master_dataout_tag = 4'((i - 1) * 5);
         step();
      end
      step(2);
      check("conc_wr_n", 132'(wr_got.size()), 132'(100));
      check("conc_rd_n", 132'(md_got.size()), 132'(100));
      for (int j = 0; j < 100; j++) begin
         check("conc_wr_beat", wr_got[j], {4'(j * 3), wdata(j)});
         check("conc_rd_beat", md_got[j], {4'(j * 5), rdata(j)});
      end
      check("conc_end_counts", 132'({wr_count, rd_count}), 132'(0));
      check("conc_no_err", 132'(err_tag_mismatch), 132'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
